px_ram_sp_ctrl: RTL and testbench

Request/response front-end for the single-port RAM macro `PX_RAM_SP` (registered read, one-cycle latency, one access per cycle). It converts a valid/ready request stream of reads and writes into RAM `ena`/`wen`/`addr`/`data_in` strobes and captures the RAM's `data_out` into a small response FIFO. That FIFO gives the consumer full valid/ready backpressure. Upstream masters (fetch buffers, scratchpad clients) connect here and never drive the RAM directly.

---
 rtl/px_ram_sp_ctrl.sv | 92 +++++++++
 tb/tb_px_ram_sp_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/px_ram_sp_ctrl.sv
// Valid/ready front-end for the PX_RAM_SP single-port RAM macro.
// Credit-gated reads feed a small response FIFO with full backpressure.
module px_ram_sp_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_ena,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  idle
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_ptr_nxt;
    logic [CW-1:0]         occ;
    logic [CW-1:0]         credit;
    logic                  inflight;
    logic                  acc;
    logic                  push;
    logic                  pop;

    // Every slot is either occupied or reserved by the read in flight.
    assign credit    = DEPTH_C - occ - {{PW{1'b0}}, inflight};
    assign req_ready = rst_n & (req_wr | (credit != '0));
    assign acc       = req_valid & req_ready;

    assign ram_ena   = acc;
    assign ram_wen   = acc & req_wr;
    assign ram_addr  = req_addr;
    assign ram_wdata = req_wdata;

    assign push       = inflight;
    assign rsp_valid  = (occ != '0);
    assign pop        = rsp_valid & rsp_ready;
    assign idle       = ~inflight & (occ == '0);
    assign rd_ptr_nxt = rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight  <= 1'b0;
            occ       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rsp_rdata <= '0;
        end else begin
            inflight <= acc & ~req_wr;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr_nxt;
            unique case ({push, pop})
                2'b10:   occ <= occ + ONE_C;
                2'b01:   occ <= occ - ONE_C;
                default: occ <= occ;
            endcase
            // Head register tracks the entry at rd_ptr after this edge.
            if (push && occ == '0) begin
                rsp_rdata <= ram_rdata;
            end else if (pop) begin
                if (occ > ONE_C)
                    rsp_rdata <= fifo_mem[rd_ptr_nxt];
                else if (push)
                    rsp_rdata <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push)
            fifo_mem[wr_ptr] <= ram_rdata;
    end

endmodule

// File: tb/tb_px_ram_sp_ctrl.sv
// Directed bench for px_ram_sp_ctrl with a behavioural registered-read
// single-port RAM attached.
module tb_px_ram_sp_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          ram_ena;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          idle;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    logic [DW-1:0] got[$];
    int            got_cyc[$];
    logic [DW-1:0] shadow [16];

    always #5 clk = ~clk;

    px_ram_sp_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RSP_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .ram_ena  (ram_ena),
        .ram_wen  (ram_wen),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .idle     (idle)
    );

    // Registered-read RAM macro model
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wen)
                ram_mem[ram_addr] <= ram_wdata;
            else
                ram_q <= ram_mem[ram_addr];
        end
    end
    assign ram_rdata = ram_q;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            got.push_back(rsp_rdata);
            got_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 30 && !idle; k++) tick();
        chk("wait_idle", 32'(idle), 32'd1);
    endtask

    initial begin
        int drops;
        int bad;
        int n;

        // Reset with a request pending
        rst_n = 1'b0;
        req_valid = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_ram_ena", 32'(ram_ena), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Write then read same address
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
        #1;
        chk("wr_ena", 32'({ram_ena, ram_wen}), 32'b11);
        tick();
        req_wr = 1'b0;
        #1;
        chk("rd_ena", 32'({ram_ena, ram_wen}), 32'b10);
        tick();
        req_valid = 1'b0;
        chk("rd_t2_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("rd_t3_valid", 32'(rsp_valid), 32'd1);
        chk("rd_t3_data", 32'(rsp_rdata), 32'hA5);
        chk("rd_t3_idle", 32'(idle), 32'd0);
        rsp_ready = 1'b1;
        tick();
        chk("rd_popped", 32'(rsp_valid), 32'd0);
        chk("rd_idle", 32'(idle), 32'd1);

        // Streaming fill and read-back
        drops = 0;
        req_valid = 1'b1;
        req_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_addr = 4'(i);
            req_wdata = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
            #1;
            if (!req_ready) drops++;
            tick();
        end
        got.delete(); got_cyc.delete();
        req_wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req_addr = 4'(i);
            #1;
            if (!req_ready) drops++;
            tick();
        end
        req_valid = 1'b0;
        for (int k = 0; k < 20 && got.size() < 16; k++) tick();
        chk("stream_drops", 32'(drops), 32'd0);
        chk("stream_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("stream_data%0d", i), 32'(got[i]), 32'(shadow[i]));
        if (got.size() == 16)
            chk("stream_consec", 32'(got_cyc[15] - got_cyc[0]), 32'd15);
        wait_idle();

        // Backpressure
        got.delete(); got_cyc.delete();
        rsp_ready = 1'b0;
        n = 0;
        req_valid = 1'b1;
        req_wr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req_addr = 4'(n);
            #1;
            if (req_ready) n++;
            tick();
        end
        chk("bp_accepted", 32'(n), 32'd4);
        req_addr = 4'(n);
        #1;
        chk("bp_read_blocked", 32'(req_ready), 32'd0);
        req_wr = 1'b1; req_addr = 4'd15; req_wdata = 8'h77;
        #1;
        chk("bp_write_ok", 32'(req_ready), 32'd1);
        shadow[15] = 8'h77;
        tick();
        req_wr = 1'b0;
        req_addr = 4'(n);
        rsp_ready = 1'b1;
        #1;
        chk("bp_no_passthru", 32'(req_ready), 32'd0);
        tick();
        chk("bp_resume", 32'(req_ready), 32'd1);
        for (int k = 0; k < 20 && n < 8; k++) begin
            req_addr = 4'(n);
            #1;
            if (req_ready) n++;
            tick();
        end
        req_valid = 1'b0;
        chk("bp_all_issued", 32'(n), 32'd8);
        for (int k = 0; k < 20 && got.size() < 8; k++) tick();
        chk("bp_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < got.size() && i < 8; i++)
            chk($sformatf("bp_data%0d", i), 32'(got[i]), 32'(shadow[i]));
        wait_idle();

        // Reset while a read is in flight
        got.delete(); got_cyc.delete();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd5;
        tick();
        req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("mid_rst_no_rsp", 32'(got.size()), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 10 && got.size() < 1; k++) tick();
        chk("mid_rst_count", 32'(got.size()), 32'd1);
        if (got.size() > 0)
            chk("mid_rst_data", 32'(got[0]), 32'(shadow[5]));
        wait_idle();

        // Steady state at two entries with pointer wrap
        got.delete(); got_cyc.delete();
        rsp_ready = 1'b0;
        drops = 0;
        bad = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_addr = 4'(i % 16);
            if (i == 3) rsp_ready = 1'b1;
            #1;
            if (!req_ready) drops++;
            if (i >= 3 && got.size() != i - 3) bad++;
            tick();
        end
        req_valid = 1'b0;
        chk("pp_drops", 32'(drops), 32'd0);
        chk("pp_occ_const", 32'(bad), 32'd0);
        for (int k = 0; k < 30 && got.size() < 20; k++) tick();
        chk("pp_count", 32'(got.size()), 32'd20);
        for (int i = 0; i < got.size() && i < 20; i++)
            chk($sformatf("pp_data%0d", i), 32'(got[i]),
                32'(shadow[i % 16]));
        wait_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
